// File: rtl/vx_commit_arb.sv
// vx_commit_arb: round-robin commit arbiter that merges execute-unit commit streams onto one
// registered writeback port, holding the grant across multi-beat commits.
module vx_commit_arb #(
    parameter int NUM_REQS   = 6,
    parameter int DATA_WIDTH = 64,
    parameter int SEL_BITS   = $clog2(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_in,
    input  logic [NUM_REQS-1:0]          req_eop_in,
    output logic [NUM_REQS-1:0]          req_ready_in,
    output logic                         rsp_valid_out,
    output logic [DATA_WIDTH-1:0]        rsp_data_out,
    output logic                         rsp_eop_out,
    output logic [SEL_BITS-1:0]          rsp_sel_out,
    input  logic                         rsp_ready_out,
    output logic [31:0]                  stall_cycles
);
    logic                  can_load;
    logic                  found;
    logic                  fire;
    logic                  locked;
    logic [SEL_BITS-1:0]   grant;
    logic [SEL_BITS-1:0]   idx;
    logic [SEL_BITS-1:0]   last_grant;
    logic [SEL_BITS-1:0]   lock_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_eop;

    assign can_load = !rsp_valid_out || rsp_ready_out;
    assign fire     = can_load && found;

    // Scan from the farthest offset down so the nearest valid source after last_grant wins.
    always_comb begin
        grant = lock_idx;
        idx   = lock_idx;
        found = req_valid_in[lock_idx];
        if (!locked) begin
            found = 1'b0;
            for (int k = NUM_REQS; k >= 1; k--) begin
                idx = SEL_BITS'((int'(last_grant) + k) % NUM_REQS);
                if (req_valid_in[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_eop  = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant == SEL_BITS'(i)) begin
                grant_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                grant_eop  = req_eop_in[i];
            end
        end
    end

    assign req_ready_in = (!reset && fire) ? NUM_REQS'(1) << grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_out <= 1'b0;
            rsp_data_out  <= '0;
            rsp_eop_out   <= 1'b0;
            rsp_sel_out   <= '0;
            stall_cycles  <= '0;
            locked        <= 1'b0;
            lock_idx      <= '0;
            last_grant    <= SEL_BITS'(NUM_REQS - 1);
        end else begin
            if (rsp_valid_out && !rsp_ready_out)
                stall_cycles <= stall_cycles + 32'd1;
            if (can_load)
                rsp_valid_out <= found;
            if (fire) begin
                rsp_data_out <= grant_data;
                rsp_eop_out  <= grant_eop;
                rsp_sel_out  <= grant;
                last_grant   <= grant;
                locked       <= !grant_eop;
                if (!grant_eop)
                    lock_idx <= grant;
            end
        end
    end
endmodule

// File: tb/tb_vx_commit_arb.sv
// tb_vx_commit_arb: directed scenarios plus randomized traffic checked against a
// cycle-level reference model of the arbitration rules.
module tb_vx_commit_arb;
    localparam int N  = 6;
    localparam int DW = 64;
    localparam int SB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid_in;
    logic [N*DW-1:0] req_data_in;
    logic [N-1:0]    req_eop_in;
    logic [N-1:0]    req_ready_in;
    logic            rsp_valid_out;
    logic [DW-1:0]   rsp_data_out;
    logic            rsp_eop_out;
    logic [SB-1:0]   rsp_sel_out;
    logic            rsp_ready_out;
    logic [31:0]     stall_cycles;
    logic [DW-1:0]   din [N];

    int checks = 0;
    int errors = 0;

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_eop;
    int            m_sel;
    int            m_last;
    logic          m_lock;
    int            m_lidx;
    logic [31:0]   m_stall;

    vx_commit_arb #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_eop_in(req_eop_in),
        .req_ready_in(req_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_eop_out(rsp_eop_out),
        .rsp_sel_out(rsp_sel_out), .rsp_ready_out(rsp_ready_out), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data_in = '0;
        for (int i = 0; i < N; i++) req_data_in[i*DW +: DW] = din[i];
    end

    // Which source the rules say should win this cycle, -1 if none.
    function automatic int pick();
        if (m_lock) return req_valid_in[m_lidx] ? m_lidx : -1;
        for (int k = 1; k <= N; k++)
            if (req_valid_in[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick();
        return (!reset && (!m_valid || rsp_ready_out) && g >= 0) ? N'(1) << g : '0;
    endfunction

    // Advance one clock: model consumes the inputs seen before the edge, returns at negedge.
    task automatic tick();
        int g;
        logic cl, r, rr;
        logic [N-1:0] e;
        logic [DW-1:0] d [N];
        g = pick();
        cl = !m_valid || rsp_ready_out;
        r = reset;
        rr = rsp_ready_out;
        e = req_eop_in;
        d = din;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_eop = 0; m_sel = 0;
            m_last = N - 1; m_lock = 0; m_lidx = 0; m_stall = '0;
        end else begin
            if (m_valid && !rr) m_stall = m_stall + 32'd1;
            if (cl) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_data = d[3'(g)];
                    m_eop = e[g];
                    m_sel = g;
                    m_last = g;
                    m_lock = !e[g];
                    if (!e[g]) m_lidx = g;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; req_valid_in = '0; req_eop_in = '1; rsp_ready_out = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_valid_in = '1; req_eop_in = '1; rsp_ready_out = 1;
        for (int i = 0; i < N; i++) din[i] = DW'(i + 1);
        #1;
        checks++;
        if (req_ready_in !== 6'b0) begin errors++; $display("FAIL reset_ready: got %b want 000000", req_ready_in); end
        tick(); tick();
        checks++;
        if ({rsp_valid_out, rsp_eop_out, rsp_sel_out, rsp_data_out, stall_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%b s=%0d d=%h st=%0d want all zero",
                     rsp_valid_out, rsp_eop_out, rsp_sel_out, rsp_data_out, stall_cycles);
        end
        reset = 0; req_valid_in = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_valid_in = 6'b000100; din[2] = 64'hA5; req_eop_in = '1; rsp_ready_out = 1;
        #1;
        checks++;
        if (req_ready_in !== 6'b000100) begin errors++; $display("FAIL single_ready: got %b want 000100", req_ready_in); end
        tick();
        req_valid_in = '0;
        checks++;
        if (rsp_valid_out !== 1 || rsp_data_out !== 64'hA5 || rsp_sel_out !== 3'd2 || rsp_eop_out !== 1) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%0d e=%b want v=1 d=a5 s=2 e=1",
                     rsp_valid_out, rsp_data_out, rsp_sel_out, rsp_eop_out);
        end
        tick();
        checks++;
        if (rsp_valid_out !== 0) begin errors++; $display("FAIL single_drain: got v=%b want 0", rsp_valid_out); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] want;
        int cnt [N];
        do_reset();
        req_valid_in = '1; req_eop_in = '1; rsp_ready_out = 1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < 2 * N; i++) begin
            for (int j = 0; j < N; j++) din[j] = {$urandom, $urandom};
            want = din[i % N];
            tick();
            cnt[rsp_sel_out]++;
            checks++;
            if (rsp_valid_out !== 1 || int'(rsp_sel_out) != i % N || rsp_data_out !== want) begin
                errors++;
                $display("FAIL rr_order[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, rsp_valid_out, rsp_sel_out, rsp_data_out, i % N, want);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] != 2) begin errors++; $display("FAIL rr_fair[%0d]: got %0d grants want 2", i, cnt[i]); end
        end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_burst();
        logic [N-1:0] vs [5] = '{6'b010000, 6'b010001, 6'b000001, 6'b010001, 6'b000001};
        logic [N-1:0] rdy [5] = '{6'b010000, 6'b010000, 6'b000000, 6'b010000, 6'b000001};
        logic [2:0] eop4 = 3'b100;
        int beat = 0;
        do_reset();
        rsp_ready_out = 1; req_eop_in = '1;
        for (int c = 0; c < 5; c++) begin
            req_valid_in = vs[c];
            din[4] = DW'(64'h4000 + beat); din[0] = 64'h0BAD;
            req_eop_in[4] = eop4[beat];
            #1;
            checks++;
            if (req_ready_in !== rdy[c]) begin errors++; $display("FAIL burst_ready[%0d]: got %b want %b", c, req_ready_in, rdy[c]); end
            if (req_ready_in[4]) beat++;
            tick();
            checks++;
            if (c == 2 && rsp_valid_out !== 0) begin
                errors++; $display("FAIL burst_bubble: got v=%b want 0", rsp_valid_out);
            end else if (c != 2 && (rsp_valid_out !== 1 || int'(rsp_sel_out) != (c == 4 ? 0 : 4))) begin
                errors++; $display("FAIL burst_sel[%0d]: got v=%b s=%0d want v=1 s=%0d", c, rsp_valid_out, rsp_sel_out, c == 4 ? 0 : 4);
            end
        end
        checks++;
        if (rsp_eop_out !== 1 || rsp_data_out !== 64'h0BAD) begin
            errors++; $display("FAIL burst_tail: got e=%b d=%h want e=1 d=bad", rsp_eop_out, rsp_data_out);
        end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        logic [DW-1:0] held;
        do_reset();
        req_valid_in = '1; req_eop_in = '1; rsp_ready_out = 1;
        for (int j = 0; j < N; j++) din[j] = DW'(64'hC0 + j);
        tick();
        held = rsp_data_out;
        s0 = stall_cycles;
        rsp_ready_out = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready_in !== 6'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 000000", c, req_ready_in); end
            tick();
            checks++;
            if (rsp_valid_out !== 1 || rsp_sel_out !== 3'd0 || rsp_data_out !== held) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=0 d=%h", c, rsp_valid_out, rsp_sel_out, rsp_data_out, held);
            end
        end
        checks++;
        if (stall_cycles !== s0 + 32'd5) begin errors++; $display("FAIL bp_stall: got %0d want %0d", stall_cycles, s0 + 32'd5); end
        rsp_ready_out = 1;
        #1;
        checks++;
        if (req_ready_in !== 6'b000010) begin errors++; $display("FAIL bp_release_ready: got %b want 000010", req_ready_in); end
        tick();
        checks++;
        if (rsp_sel_out !== 3'd1 || rsp_data_out !== 64'hC1) begin
            errors++; $display("FAIL bp_release_sel: got s=%0d d=%h want s=1 d=c1", rsp_sel_out, rsp_data_out);
        end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req_valid_in = 6'b000010; req_eop_in = 6'b111101; rsp_ready_out = 1;
        tick();
        reset = 1; req_valid_in = 6'b000011;
        #1;
        checks++;
        if (req_ready_in !== 6'b0) begin errors++; $display("FAIL rml_ready_in_reset: got %b want 000000", req_ready_in); end
        tick();
        reset = 0;
        checks++;
        if (rsp_valid_out !== 0) begin errors++; $display("FAIL rml_valid: got %b want 0", rsp_valid_out); end
        req_eop_in = '1;
        #1;
        checks++;
        if (req_ready_in !== 6'b000001) begin errors++; $display("FAIL rml_grant: got %b want 000001", req_ready_in); end
        tick();
        checks++;
        if (rsp_sel_out !== 3'd0) begin errors++; $display("FAIL rml_sel: got %0d want 0", rsp_sel_out); end
        req_valid_in = '0;
        tick();
    endtask

    task automatic test_stall_wrap();
        do_reset();
        req_valid_in = 6'b000001; req_eop_in = '1; rsp_ready_out = 1;
        tick();
        req_valid_in = '0; rsp_ready_out = 0;
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        m_stall = 32'hFFFF_FFFE;
        tick(); tick();
        checks++;
        if (stall_cycles !== 32'h0 || m_stall !== 32'h0) begin
            errors++; $display("FAIL stall_wrap: got %h want 00000000", stall_cycles);
        end
        rsp_ready_out = 1;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(99) == 0);
            req_valid_in = N'($urandom) & N'($urandom | $urandom);
            for (int j = 0; j < N; j++) begin
                req_eop_in[j] = ($urandom_range(9) < 7);
                din[j] = {$urandom, $urandom};
            end
            rsp_ready_out = ($urandom_range(3) != 0);
            #1;
            checks++;
            if (req_ready_in !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready_in, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_out !== m_valid || stall_cycles !== m_stall ||
                (m_valid && (rsp_data_out !== m_data || rsp_eop_out !== m_eop || int'(rsp_sel_out) != m_sel))) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b s=%0d e=%b d=%h st=%0d want v=%b s=%0d e=%b d=%h st=%0d",
                         c, rsp_valid_out, rsp_sel_out, rsp_eop_out, rsp_data_out, stall_cycles,
                         m_valid, m_sel, m_eop, m_data, m_stall);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; req_valid_in = '0; req_eop_in = '1; rsp_ready_out = 1;
        for (int i = 0; i < N; i++) din[i] = '0;
        m_valid = 0; m_data = '0; m_eop = 0; m_sel = 0; m_last = N - 1; m_lock = 0; m_lidx = 0; m_stall = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_reset_mid_lock();
        test_stall_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_commit_arb.md
# vx_commit_arb

Round-robin commit arbiter for the execute stage. It merges the commit streams of the execute units (ALU, LD, ST, CSR, FPU, GPU) onto a single registered writeback port. Multi-beat commits (eop=0 until the last beat) hold the grant until their final beat. The block sits between the execute units' commit outputs and the writeback/commit stage, and exports a backpressure stall counter for the pipeline perf CSRs.

## Interface
- NUM_REQS, 6: number of commit sources; must be ≥2. Index 0 = ALU, 1 = LD, 2 = ST, 3 = CSR, 4 = FPU, 5 = GPU.
- DATA_WIDTH, 64: payload bits per source (packed wid/tmask/PC/rd/wb/data), excluding eop.
- SEL_BITS, $clog2(NUM_REQS): width of the grant index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  NUM_REQS  per-source commit valid.
- req_data_in  in  NUM_REQS*DATA_WIDTH  per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_eop_in  in  NUM_REQS  per-source last-beat flag.
- req_ready_in  out  NUM_REQS  per-source accept; one-hot or zero.
- rsp_valid_out  out  1  registered commit valid.
- rsp_data_out  out  DATA_WIDTH  registered payload.
- rsp_eop_out  out  1  registered eop.
- rsp_sel_out  out  SEL_BITS  source index of the current output beat.
- rsp_ready_out  in  1  writeback accept.
- stall_cycles  out  32  count of cycles with rsp_valid_out=1 and rsp_ready_out=0; wraps at 2^32.

## Operation
- Beat transfer: an input beat transfers when req_valid_in[i] && req_ready_in[i]. An output beat transfers when rsp_valid_out && rsp_ready_out.
- can_load = !rsp_valid_out || rsp_ready_out. This allows one beat per cycle at full throughput.
- Grant, unlocked: round-robin over valid sources. Search starts at (last_grant+1) mod NUM_REQS and the first valid source wins.
- req_ready_in[g] = can_load && valid[g] && granted. All other bits are 0.
- Combinational path from rsp_ready_out to req_ready_in is permitted. There is no path from req_valid_in to req_valid_in.
- On a transfer from g:
  - rsp_data_out/rsp_eop_out/rsp_sel_out <= req_data/eop/g.
  - rsp_valid_out <= 1.
  - last_grant <= g.
- If req_eop_in[g]=0 on a transfer:
  - lock <= 1 and lock_idx <= g.
  - While locked, only lock_idx may be granted, even if it deasserts valid for some cycles. Other sources wait.
  - A transfer with eop=1 from lock_idx clears lock in the same edge.
- If can_load and no transfer occurs: rsp_valid_out <= 0. Payload registers hold their last value.
- If !can_load: all outputs hold and all req_ready_in = 0.
- stall_cycles increments on every cycle where rsp_valid_out && !rsp_ready_out.
- Reset values:
  - rsp_valid_out = 0, rsp_data_out = 0, rsp_eop_out = 0, rsp_sel_out = 0.
  - stall_cycles = 0, lock = 0, lock_idx = 0.
  - last_grant = NUM_REQS-1, so source 0 has first priority after reset.
  - req_ready_in = 0 while reset is high.
- Reset mid-operation, including mid-lock: all state returns to reset values at the next edge. A partially delivered multi-beat commit is dropped; upstream units are reset in the same cycle.

## Timing
- Latency: a beat accepted at edge N appears on rsp_*_out from edge N until it transfers.
- Throughput: one beat per cycle when rsp_ready_out is held at 1.
- Fairness: with all NUM_REQS sources continuously valid and single-beat, each source is granted once in every NUM_REQS consecutive transfers.
- Locked multi-beat bursts may delay other sources by the full burst length.
- Simultaneous output transfer and new input accept in one cycle: the output register is replaced and rsp_valid_out stays 1.
- Source valid drop while locked: no grant that cycle, rsp_valid_out drops after the current beat drains, and the lock is retained.
- Wrap-around: the round-robin search after last_grant = NUM_REQS-1 starts at 0.
- stall_cycles wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset, then source 2 only, single beat, data=0xA5, rsp_ready_out=1 → req_ready_in=6'b000100 in cycle 0; next cycle rsp_valid_out=1, rsp_data_out=0xA5, rsp_sel_out=2, rsp_eop_out=1.
- All 6 sources continuously valid, eop=1, rsp_ready_out=1 → grant order 0,1,2,3,4,5,0,… with one output beat every cycle and no bubbles.
- Source 4 sends a 3-beat burst (eop=0,0,1) while source 0 stays valid → output sel 4,4,4, then 0. Source 0's ready is held 0 during the burst, including a cycle where source 4 deasserts valid mid-burst.
- rsp_ready_out held 0 for 5 cycles with rsp_valid_out=1 → outputs frozen, all req_ready_in=0, stall_cycles increases by exactly 5. On release, the held beat transfers and the next grant follows round-robin.
- Reset asserted during a locked burst from source 1, then sources 0 and 1 valid → lock cleared, rsp_valid_out=0 after the edge; first post-reset grant goes to source 0.
- stall_cycles preset near wrap (force 0xFFFFFFFE), two stall cycles → reads 0x00000000.
